// File: rtl/bcd_pkg.sv
// Shared BCD arithmetic types and constants for the digit-serial subtractor
// and its single-digit datapath.
package bcd_pkg;

    localparam int BCD_W     = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int BCD_RADIX = 10;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } bcd_sub_state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtractor: d = x - y - bin, with a +10
// correction and a borrow out whenever the raw difference goes negative.
import bcd_pkg::*;

module bcd_digit_sub (
    input  bcd_digit_t x,
    input  bcd_digit_t y,
    input  logic       bin,
    output bcd_digit_t d,
    output logic       bout
);

    logic [4:0] t;
    logic [4:0] t_corr;

    // Five-bit two's-complement difference; bit 4 is the sign for valid digits.
    always_comb begin
        t      = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
        t_corr = t + 5'(BCD_RADIX);
        bout   = t[4];
        d      = bout ? t_corr[3:0] : t[3:0];
    end

endmodule

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial packed-BCD subtractor, diff = a - b - borrow_in, LSD first.
// Optional BCD_SUB_SIGN_MAG_EN: negative results are re-complemented to sign/magnitude.
//
// state | meaning
// IDLE  | waiting for start; operands, borrow and invalid latched on accept
// RUN   | one digit of a - b - brw per cycle, LSD first
// FIX   | one digit of 0 - diff per cycle to recover the magnitude
// DONE  | single-cycle done pulse, results stable
import bcd_pkg::*;

module bcd_subtractor_serial #(
    parameter int DIGITS = 4,
    parameter int DW     = 4 * DIGITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          borrow_in,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] diff,
    output logic          borrow_out,
    output logic          invalid,
    output logic          neg
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    bcd_sub_state_t state, state_nxt;

    logic [DW-1:0]    a_q;
    logic [DW-1:0]    b_q;
    logic [DW-1:0]    diff_q;
    logic [IDX_W-1:0] idx;
    logic             brw;
    logic             borrow_out_q;
    logic             invalid_q;
    logic             nib_bad;
    logic             last_digit;
    bcd_digit_t       dx, dy, dd;
    logic             dbout;

    always_comb begin
        nib_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[i*BCD_W +: BCD_W] > BCD_MAX || b[i*BCD_W +: BCD_W] > BCD_MAX)
                nib_bad = 1'b1;
        end
    end

    // FIX reuses the same digit slice with a zero minuend and diff as subtrahend.
    always_comb begin
        dx = a_q[idx*BCD_W +: BCD_W];
        dy = b_q[idx*BCD_W +: BCD_W];
        if (state == FIX) begin
            dx = '0;
            dy = diff_q[idx*BCD_W +: BCD_W];
        end
    end

    bcd_digit_sub u_digit (
        .x    (dx),
        .y    (dy),
        .bin  (brw),
        .d    (dd),
        .bout (dbout)
    );

    assign last_digit = (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (last_digit) begin
`ifdef BCD_SUB_SIGN_MAG_EN
                    if (dbout && !invalid_q) state_nxt = FIX;
                    else                     state_nxt = DONE;
`else
                    state_nxt = DONE;
`endif
                end
            end
            FIX:  if (last_digit) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            diff_q       <= '0;
            idx          <= '0;
            brw          <= 1'b0;
            borrow_out_q <= 1'b0;
            invalid_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q          <= a;
                        b_q          <= b;
                        brw          <= borrow_in;
                        idx          <= '0;
                        diff_q       <= '0;
                        borrow_out_q <= 1'b0;
                        invalid_q    <= nib_bad;
                    end
                end
                RUN: begin
                    // Invalid operands leave diff at its cleared value.
                    if (!invalid_q) diff_q[idx*BCD_W +: BCD_W] <= dd;
                    brw <= dbout;
                    idx <= last_digit ? '0 : idx + 1'b1;
                    if (last_digit) begin
                        borrow_out_q <= dbout && !invalid_q;
                        if (dbout && !invalid_q) brw <= 1'b0;
                    end
                end
                FIX: begin
                    diff_q[idx*BCD_W +: BCD_W] <= dd;
                    brw <= dbout;
                    idx <= last_digit ? '0 : idx + 1'b1;
                    if (last_digit) borrow_out_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_SUB_SIGN_MAG_EN
    logic neg_q;

    always_ff @(posedge clk) begin
        if (rst)                              neg_q <= 1'b0;
        else if (state == IDLE && start)      neg_q <= 1'b0;
        else if (state == FIX && last_digit)  neg_q <= 1'b1;
    end

    assign neg = neg_q;
`else
    assign neg = 1'b0;
`endif

    assign busy       = (state == RUN) || (state == FIX);
    assign done       = (state == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign invalid    = invalid_q;

endmodule
